// File: rtl/temp_bram_reader_if.sv
// Output stream of the temp BRAM reader: data with valid/ready handshake and an end-of-pass flag.
interface temp_bram_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] m_data_o;
   logic                  m_valid_o;
   logic                  m_ready_i;
   logic                  m_last_o;

   modport master (
      output m_data_o,
      output m_valid_o,
      output m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o,
      input  m_valid_o,
      input  m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/temp_bram_reader.sv
// Walks temp BRAM indices 0..len-1, absorbs the 1-cycle read latency in a 2-entry FIFO,
// and streams the entries out with a last flag; optionally pulses the BRAM clear at the end.
module temp_bram_reader #(
   parameter int MAC_CNT    = 128,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = $clog2(MAC_CNT)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   input  logic                  clear_en_i,
   input  logic                  wr_temp_en_i,
   output logic                  rd_temp_en_o,
   output logic [ADDR_WIDTH-1:0] temp_bram_index_o,
   input  logic [DATA_WIDTH-1:0] bram_data_i,
   output logic                  clear_o,
   output logic                  busy_o,
   output logic                  done_o,
   temp_bram_reader_if.master    m
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAC_CNT);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [ADDR_WIDTH:0]         r_len;
   logic                        r_clear_en;
   logic [ADDR_WIDTH:0]         r_issued;
   logic                        r_inflight;
   logic                        r_inflight_last;
   logic [1:0][DATA_WIDTH-1:0]  r_mem;
   logic [1:0]                  r_last;
   logic                        r_wptr;
   logic                        r_rptr;
   logic [1:0]                  r_cnt;

   logic [ADDR_WIDTH:0]         w_len_sat;
   logic                        w_valid;
   logic                        w_pop;
   logic [2:0]                  w_occ;
   logic [1:0]                  w_cnt_nxt;
   logic                        w_issue;
   logic                        w_issue_last;

   assign w_len_sat = (len_i > MAX_LEN) ? MAX_LEN : len_i;
   assign w_valid   = (r_cnt != 2'd0);
   assign w_pop     = w_valid & m.m_ready_i;
   // Credit: buffered + in-flight entries, net of this cycle's pop, must leave room for one more.
   assign w_occ     = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_cnt_nxt = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

   assign w_issue      = (r_state == S_READ) && (r_issued < r_len) && !wr_temp_en_i && (w_occ < 3'd2);
   assign w_issue_last = w_issue && (r_issued == (r_len - 1'b1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_nxt = (w_len_sat == '0) ? S_DONE : S_READ;
         S_READ:  if (w_issue_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if ((w_cnt_nxt == 2'd0) && !r_inflight) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_temp_en_o      = w_issue;
      temp_bram_index_o = w_issue ? r_issued[ADDR_WIDTH-1:0] : '0;
      busy_o            = (r_state != S_IDLE);
      done_o            = (r_state == S_DONE);
      clear_o           = (r_state == S_DONE) && r_clear_en;
      m.m_valid_o       = w_valid;
      m.m_data_o        = r_mem[r_rptr];
      m.m_last_o        = w_valid && r_last[r_rptr];
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_len           <= '0;
         r_clear_en      <= 1'b0;
         r_issued        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start_i) begin
            r_len      <= w_len_sat;
            r_clear_en <= clear_en_i;
            r_issued   <= '0;
         end else if (w_issue) begin
            r_issued <= r_issued + 1'b1;
         end
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue_last;
      end
   end

   // Read data arrives the cycle after issue and is captured straight into the FIFO.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_mem  <= '0;
         r_last <= '0;
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_cnt  <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_mem[r_wptr]  <= bram_data_i;
            r_last[r_wptr] <= r_inflight_last;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_temp_bram_reader.sv
// Randomized bench for temp_bram_reader: BRAM model, stream sink and a pass-level reference model.
module tb_temp_bram_reader;
   localparam int MAC_CNT = 128;
   localparam int DW      = 8;
   localparam int AW      = 7;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          start_i = 1'b0;
   logic [AW:0]   len_i = '0;
   logic          clear_en_i = 1'b0;
   logic          wr_temp_en_i = 1'b0;
   logic          rd_temp_en_o;
   logic [AW-1:0] temp_bram_index_o;
   logic [DW-1:0] bram_data_i;
   logic          clear_o, busy_o, done_o;

   temp_bram_reader_if #(.DATA_WIDTH(DW)) mif();

   temp_bram_reader #(.MAC_CNT(MAC_CNT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .len_i(len_i),
      .clear_en_i(clear_en_i), .wr_temp_en_i(wr_temp_en_i),
      .rd_temp_en_o(rd_temp_en_o), .temp_bram_index_o(temp_bram_index_o),
      .bram_data_i(bram_data_i), .clear_o(clear_o), .busy_o(busy_o),
      .done_o(done_o), .m(mif)
   );

   always #5 clk_i = ~clk_i;

   logic [DW-1:0] mem [MAC_CNT];
   always @(posedge clk_i) if (rd_temp_en_o && !wr_temp_en_i) bram_data_i <= mem[temp_bram_index_o];

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int ready_mode = 0;
   initial begin
      mif.m_ready_i = 1'b1;
      forever begin
         @(posedge clk_i); #1;
         case (ready_mode)
            0:       mif.m_ready_i = 1'b1;
            1:       mif.m_ready_i = 1'($urandom_range(0, 1));
            default: mif.m_ready_i = 1'b0;
         endcase
      end
   end

   int checks = 0;
   int failures = 0;
   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Pass-level model: beat b carries mem[b], last on b==len-1, done once right after the last beat.
   bit            pass_active = 1'b0;
   int            exp_len, rd_next, beats, dones, clears, busy_cyc, last_hs_cyc, outstanding, last_rd_idx, start_cyc;
   bit            exp_clear;
   int            rd_cyc [MAC_CNT];
   int            hs_cyc [MAC_CNT];
   logic [DW-1:0] hs_dat [MAC_CNT];
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;

   always @(negedge clk_i) begin
      if (!rstn_i) begin
         prev_stall  = 1'b0;
         outstanding = 0;
      end else if (pass_active) begin
         if (busy_o) busy_cyc++;
         if (rd_temp_en_o) begin
            chk(!wr_temp_en_i, "rd_during_wr", 1, 0);
            chk(rd_next < exp_len, "rd_count", rd_next + 1, exp_len);
            chk(int'(temp_bram_index_o) == rd_next, "rd_index", int'(temp_bram_index_o), rd_next);
            if (rd_next < MAC_CNT) rd_cyc[rd_next] = cyc;
            last_rd_idx = int'(temp_bram_index_o);
            rd_next++;
            outstanding++;
         end
         if (prev_stall)
            chk(mif.m_valid_o && mif.m_data_o == prev_data, "hold_stable", int'(mif.m_data_o), int'(prev_data));
         if (mif.m_valid_o && mif.m_ready_i) begin
            if (beats < exp_len) begin
               chk(mif.m_data_o == mem[beats], "beat_data", int'(mif.m_data_o), int'(mem[beats]));
               chk(mif.m_last_o == (beats == exp_len - 1), "beat_last", int'(mif.m_last_o), int'(beats == exp_len - 1));
               hs_cyc[beats] = cyc;
               hs_dat[beats] = mif.m_data_o;
            end else begin
               chk(1'b0, "extra_beat", beats + 1, exp_len);
            end
            beats++;
            last_hs_cyc = cyc;
            outstanding--;
         end
         chk(outstanding <= 2, "credit", outstanding, 2);
         if (done_o) begin
            dones++;
            chk(beats == exp_len, "done_after_all", beats, exp_len);
            chk(clear_o == exp_clear, "clear_with_done", int'(clear_o), int'(exp_clear));
            chk(busy_o, "busy_in_done", int'(busy_o), 1);
            if (exp_len > 0) chk(cyc - last_hs_cyc == 1, "done_timing", cyc - last_hs_cyc, 1);
         end
         if (clear_o) clears++;
         if (clear_o && !done_o) chk(1'b0, "clear_without_done", 1, 0);
         prev_stall = mif.m_valid_o && !mif.m_ready_i;
         prev_data  = mif.m_data_o;
      end else begin
         chk(!(rd_temp_en_o || mif.m_valid_o || done_o || clear_o || busy_o), "idle_quiet",
             int'({rd_temp_en_o, mif.m_valid_o, done_o, clear_o, busy_o}), 0);
         prev_stall = 1'b0;
      end
   end

   task automatic start_pass(input int len, input bit clr, input int rmode);
      exp_len = (len > MAC_CNT) ? MAC_CNT : len;
      exp_clear = clr;
      rd_next = 0; beats = 0; dones = 0; clears = 0; busy_cyc = 0;
      last_hs_cyc = 0; outstanding = 0; last_rd_idx = -1;
      ready_mode = rmode;
      @(posedge clk_i); #1;
      pass_active = 1'b1;
      start_i = 1'b1;
      len_i = len[AW:0];
      clear_en_i = clr;
      start_cyc = cyc;
   endtask

   task automatic finish_pass(input int wr_at, input int restart_at);
      int k;
      k = 0;
      while (dones == 0 && k < 3000) begin
         @(posedge clk_i); #1;
         k++;
         start_i = (k == restart_at);
         if (k == restart_at) len_i = (AW+1)'(7);
         wr_temp_en_i = (wr_at >= 0) && (k >= wr_at) && (k < wr_at + 3);
      end
      start_i = 1'b0;
      wr_temp_en_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      pass_active = 1'b0;
      chk(k < 3000, "pass_timeout", k, 3000);
      chk(dones == 1, "done_count", dones, 1);
      chk(clears == (exp_clear ? 1 : 0), "clear_count", clears, exp_clear ? 1 : 0);
      chk(beats == exp_len, "beat_count", beats, exp_len);
      chk(rd_next == exp_len, "read_count", rd_next, exp_len);
      if (exp_len == 0) chk(busy_cyc == 1, "busy_len0", busy_cyc, 1);
   endtask

   initial begin
      #12;
      chk({rd_temp_en_o, temp_bram_index_o, clear_o, mif.m_data_o, mif.m_valid_o, mif.m_last_o, busy_o, done_o} == '0,
          "reset_outputs", int'(mif.m_data_o), 0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      repeat (2) @(posedge clk_i);

      // Test 1: small pass, preloaded values, full throughput.
      for (int i = 0; i < MAC_CNT; i++) mem[i] = DW'(8'h11 * (i + 1));
      start_pass(4, 1'b0, 0);
      finish_pass(-1, -1);
      for (int i = 0; i < 4; i++) begin
         chk(hs_dat[i] == DW'(8'h11 * (i + 1)), "t1_data", int'(hs_dat[i]), 8'h11 * (i + 1));
         chk(rd_cyc[i] == start_cyc + 1 + i, "t1_rd_cycle", rd_cyc[i] - start_cyc, 1 + i);
         chk(hs_cyc[i] == start_cyc + 3 + i, "t1_hs_cycle", hs_cyc[i] - start_cyc, 3 + i);
      end
      chk(hs_cyc[3] - rd_cyc[0] == 5, "t1_span", hs_cyc[3] - rd_cyc[0], 5);

      // Test 2: full-depth pass with random backpressure and clear.
      for (int i = 0; i < MAC_CNT; i++) mem[i] = DW'(i);
      start_pass(128, 1'b1, 1);
      finish_pass(-1, -1);
      chk(hs_dat[127] == 8'd127, "t2_final", int'(hs_dat[127]), 127);

      // Test 3: write-enable stall mid-pass.
      for (int i = 0; i < MAC_CNT; i++) mem[i] = DW'($urandom);
      start_pass(8, 1'b0, 0);
      finish_pass(3, -1);

      // Test 4: zero-length pass, then start ignored while busy.
      start_pass(0, 1'b1, 0);
      finish_pass(-1, -1);
      start_pass(4, 1'b0, 1);
      finish_pass(-1, 2);

      // Test 5: reset while the stream holds data, then a fresh short pass.
      for (int i = 0; i < MAC_CNT; i++) mem[i] = DW'(i);
      start_pass(16, 1'b1, 2);
      begin
         int w;
         w = 0;
         while (!mif.m_valid_o && w < 20) begin @(negedge clk_i); w++; end
         chk(mif.m_valid_o, "t5_valid_seen", int'(mif.m_valid_o), 1);
      end
      start_i = 1'b0;
      @(posedge clk_i); #2;
      rstn_i = 1'b0;
      pass_active = 1'b0;
      #1;
      chk({rd_temp_en_o, temp_bram_index_o, clear_o, mif.m_data_o, mif.m_valid_o, mif.m_last_o, busy_o, done_o} == '0,
          "t5_reset_outputs", int'({mif.m_valid_o, busy_o, rd_temp_en_o}), 0);
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      ready_mode = 0;
      start_pass(2, 1'b0, 0);
      finish_pass(-1, -1);
      chk(hs_dat[0] == 8'd0 && hs_dat[1] == 8'd1, "t5_after_reset", int'({hs_dat[0], hs_dat[1]}), 1);

      // Test 6: oversize length saturates.
      start_pass(200, 1'b0, 1);
      finish_pass(-1, -1);
      chk(last_rd_idx == 127, "t6_final_index", last_rd_idx, 127);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
